fifo_dp_ram_prog: RTL

FIFO_DP_RAM_PROG -- requirements
Module: fifo_dp_ram_prog

---
 rtl/fifo_dp_ram_prog.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_dp_ram_prog.sv
// Synchronous FIFO on a simple dual-port RAM with a registered read port.
// Runtime-programmable almost-full/almost-empty thresholds, sticky errors.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   write, write_data : write request and word to store
//   read              : read request
//   af_level/ae_level : almost-full / almost-empty thresholds (PTR_W bits)
//   err_clear         : clears sticky overflow/underflow
//   read_data         : returned word, held between deliveries
//   read_valid        : one-cycle pulse, LATENCY cycles after accepted read
//   empty/full        : occupancy flags from registered pointers
//   almost_empty/full : level compared against runtime thresholds
//   level             : current word count
//   overflow/underflow: sticky error flags
module fifo_dp_ram_prog #(
    parameter int FIFO_DEPTH      = 256,
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int LATENCY         = 2,
    localparam int PTR_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write,
    input  logic                       read,
    input  logic [FIFO_DATA_WIDTH-1:0] write_data,
    input  logic [PTR_W-1:0]           af_level,
    input  logic [PTR_W-1:0]           ae_level,
    input  logic                       err_clear,
    output logic [FIFO_DATA_WIDTH-1:0] read_data,
    output logic                       read_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [PTR_W-1:0]           level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW  = PTR_W - 1;
    // Output-side stages after the RAM register; LATENCY >= 2 keeps NST >= 1.
    localparam int NST = LATENCY - 1;

    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_d;
    logic                       wr_acc;
    logic                       rd_acc;
    logic                       ovf_q;
    logic                       ovf_d;
    logic                       udf_q;
    logic                       udf_d;

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_DATA_WIDTH-1:0] ram_dat_q;
    logic                       ram_vld_q;
    logic [NST-1:0]             pipe_vld_q;
    logic [FIFO_DATA_WIDTH-1:0] pipe_dat_q [NST];

    // Status derived purely from registered pointers.
    assign level        = wr_ptr_q - rd_ptr_q;
    assign empty        = (level == '0);
    assign full         = (level == PTR_W'(FIFO_DEPTH));
    assign almost_full  = (level >= af_level);
    assign almost_empty = (level <= ae_level);

    assign wr_acc = write & ~full;
    assign rd_acc = read & ~empty;

    assign read_valid = pipe_vld_q[NST-1];
    assign read_data  = pipe_dat_q[NST-1];
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // A new error event on the same edge as err_clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (write && full) begin
            ovf_d = 1'b1;
        end
        if (read && empty) begin
            udf_d = 1'b1;
        end
    end

    // Storage and registered read port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= write_data;
        end
        if (rd_acc) begin
            ram_dat_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Read pipeline: valid bits reset so in-flight reads are dropped;
    // data stages load only on a valid word, so the last stage holds
    // the most recently delivered word between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_vld_q  <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < NST; i++) begin
                pipe_dat_q[i] <= '0;
            end
        end else begin
            ram_vld_q     <= rd_acc;
            pipe_vld_q[0] <= ram_vld_q;
            if (ram_vld_q) begin
                pipe_dat_q[0] <= ram_dat_q;
            end
            for (int i = 1; i < NST; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) begin
                    pipe_dat_q[i] <= pipe_dat_q[i-1];
                end
            end
        end
    end

endmodule
